// File: rtl/gpio_word_packer_pkg.sv
// Shared constants and the GPIO chunk layout for the GPIO word packer and
// its matching unpacker.
package gpio_word_packer_pkg;

    localparam int WORD_BITS       = 32;
    localparam int GPIO_CHUNK_BITS = 8;
    localparam int GPIO_LAST_BIT   = 8;

    // One GPIO bus beat: bit 8 closes the current word early.
    typedef struct packed {
        logic                       last;
        logic [GPIO_CHUNK_BITS-1:0] payload;
    } gpio_chunk_t;

    function automatic gpio_chunk_t make_chunk(
        input logic                       last,
        input logic [GPIO_CHUNK_BITS-1:0] payload
    );
        gpio_chunk_t c;
        c.last    = last;
        c.payload = payload;
        return c;
    endfunction

endpackage

// File: rtl/gpio_word_packer_out_reg.sv
// Single-entry val/rdy output register with load/drain and pass-through ready.
// Reusable as the output stage of the matching downstream unpacker.
module gpio_packer_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_drain_rdy,
    output logic         o_val,
    output logic [W-1:0] o_data,
    output logic         o_load_rdy
);

    logic         r_val;
    logic [W-1:0] r_data;

    // A new entry may load when empty or when the held entry leaves this cycle.
    assign o_load_rdy = !r_val || i_drain_rdy;
    assign o_val      = r_val;
    assign o_data     = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val  <= 1'b0;
            r_data <= '0;
        end else if (i_load && o_load_rdy) begin
            r_val  <= 1'b1;
            r_data <= i_load_data;
        end else if (i_drain_rdy) begin
            r_val  <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_word_packer.sv
// Packs little-endian GPIO chunks (val/rdy, bit 8 = last) into full words.
// Optional idle-flush of partial words: define GPIO_PACKER_TIMEOUT_EN.
module gpio_word_packer
    import gpio_word_packer_pkg::*;
#(
    parameter int BIT_WIDTH      = WORD_BITS,
    parameter int CHUNK_WIDTH    = GPIO_CHUNK_BITS,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_stream_val,
    input  logic [CHUNK_WIDTH:0]   i_stream_data,
    output logic                   i_stream_rdy,
    output logic                   o_stream_val,
    output logic [BIT_WIDTH-1:0]   o_stream_data,
    input  logic                   o_stream_rdy,
    output logic                   partial
);

    localparam int N     = BIT_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

    logic [BIT_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_WIDTH-1:0]   w_merged;
    logic [BIT_WIDTH-1:0]   w_load_data;
    logic [CHUNK_WIDTH-1:0] w_payload;
    logic                   w_last;
    logic                   w_load_rdy;
    logic                   w_accept;
    logic                   w_complete;
    logic                   w_flush;
    logic                   w_load;

    assign w_payload  = i_stream_data[CHUNK_WIDTH-1:0];
    assign w_last     = i_stream_data[CHUNK_WIDTH];
    assign w_accept   = i_stream_val && w_load_rdy;
    assign w_complete = w_accept && (w_last || (r_cnt == CNT_MAX));

    // Accumulator with the incoming chunk dropped into its slot; unwritten
    // upper slots are already zero because the accumulator clears per word.
    always_comb begin
        w_merged = r_acc;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_merged[i*CHUNK_WIDTH +: CHUNK_WIDTH] = w_payload;
            end
        end
    end

`ifdef GPIO_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic          w_idle;

    assign w_idle  = (r_cnt != '0) && !w_accept;
    // Flush on the idle cycle that brings the timer to its limit, or later
    // once a blocked output frees up (timer then sits saturated).
    assign w_flush = w_idle && w_load_rdy && (r_timer >= T_PRE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_accept || w_flush || (r_cnt == '0)) begin
            r_timer <= '0;
        end else if (r_timer != T_MAX) begin
            r_timer <= r_timer + TW'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    assign w_load      = w_complete || w_flush;
    assign w_load_data = w_complete ? w_merged : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_merged;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    gpio_packer_out_reg #(
        .W (BIT_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_drain_rdy (o_stream_rdy),
        .o_val       (o_stream_val),
        .o_data      (o_stream_data),
        .o_load_rdy  (w_load_rdy)
    );

    assign i_stream_rdy = w_load_rdy;
    assign partial      = (r_cnt != '0);

endmodule

// File: tb/tb_gpio_word_packer.sv
// Bench for gpio_word_packer: directed vector table, reset/timeout sequences,
// and random streaming against a byte-list reference model.
module tb_gpio_word_packer;
  import gpio_word_packer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stream_val;
  logic [8:0]  i_stream_data;
  logic        i_stream_rdy;
  logic        o_stream_val;
  logic [31:0] o_stream_data;
  logic        o_stream_rdy;
  logic        partial;

  gpio_word_packer #(
    .BIT_WIDTH      (32),
    .CHUNK_WIDTH    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_stream_val  (i_stream_val),
    .i_stream_data (i_stream_data),
    .i_stream_rdy  (i_stream_rdy),
    .o_stream_val  (o_stream_val),
    .o_stream_data (o_stream_data),
    .o_stream_rdy  (o_stream_rdy),
    .partial       (partial)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rule_viol = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  cur_bytes[$];

  typedef struct {
    logic        val;
    logic [8:0]  data;
    logic        ordy;
    logic        e_irdy;
    logic        e_oval;
    logic [31:0] e_odata;
    logic        e_part;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // driver: inputs change 1ns after the rising edge, outputs sampled at the falling edge
  task automatic drive(input logic v, input logic [8:0] d, input logic r);
    @(posedge clk);
    #1;
    i_stream_val  = v;
    i_stream_data = d;
    o_stream_rdy  = r;
    @(negedge clk);
  endtask

  function automatic void add(input logic v, input logic [8:0] d, input logic r,
                              input logic ei, input logic eo, input logic [31:0] ed,
                              input logic ep);
    vec_t x;
    x.val = v; x.data = d; x.ordy = r;
    x.e_irdy = ei; x.e_oval = eo; x.e_odata = ed; x.e_part = ep;
    vecs.push_back(x);
  endfunction

  // reference model + scoreboard, called at the falling edge of each cycle
  task automatic observe();
    logic [31:0] w;
    if (i_stream_rdy !== (!o_stream_val || o_stream_rdy)) rule_viol++;
    if (o_stream_val && o_stream_rdy) begin
      check("rand_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rand_word", o_stream_data, exp_q.pop_front());
    end
    if (i_stream_val && i_stream_rdy) begin
      cur_bytes.push_back(i_stream_data[7:0]);
      if (i_stream_data[8] || cur_bytes.size() == 4) begin
        w = '0;
        foreach (cur_bytes[j]) w = w | (32'(cur_bytes[j]) << (8 * j));
        exp_q.push_back(w);
        cur_bytes.delete();
      end
    end
  endtask

  initial begin
    int sent;
    int cyc;
    logic have;
    gpio_chunk_t ch;

    reset = 1'b0;
    i_stream_val = 1'b0;
    i_stream_data = '0;
    o_stream_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_oval", 32'(o_stream_val), 32'd0);
    check("reset_odata", o_stream_data, 32'd0);
    check("reset_partial", 32'(partial), 32'd0);
    check("reset_irdy", 32'(i_stream_rdy), 32'd1);
    reset = 1'b1;

    // val data ordy | irdy oval odata partial
    add(1, 9'h011, 1, 1, 0, 32'h0, 0);
    add(1, 9'h022, 1, 1, 0, 32'h0, 1);
    add(1, 9'h033, 1, 1, 0, 32'h0, 1);
    add(1, 9'h044, 1, 1, 0, 32'h0, 1);
    add(1, 9'h0AA, 1, 1, 1, 32'h44332211, 0);
    add(1, 9'h1BB, 1, 1, 0, 32'h44332211, 1);
    add(1, 9'h001, 1, 1, 1, 32'h0000BBAA, 0);
    add(1, 9'h002, 1, 1, 0, 32'h0000BBAA, 1);
    add(1, 9'h003, 1, 1, 0, 32'h0000BBAA, 1);
    add(1, 9'h004, 1, 1, 0, 32'h0000BBAA, 1);
    for (int i = 0; i < 10; i++) add(1, 9'h011, 0, 0, 1, 32'h04030201, 0);
    add(1, 9'h011, 1, 1, 1, 32'h04030201, 0);
    add(1, 9'h022, 1, 1, 0, 32'h04030201, 1);
    add(1, 9'h033, 1, 1, 0, 32'h04030201, 1);
    add(1, 9'h044, 1, 1, 0, 32'h04030201, 1);
    add(1, 9'h1C1, 1, 1, 1, 32'h44332211, 0);
    add(1, 9'h1C2, 1, 1, 1, 32'h000000C1, 0);
    add(1, 9'h1C3, 0, 0, 1, 32'h000000C2, 0);
    add(1, 9'h1C3, 1, 1, 1, 32'h000000C2, 0);
    add(0, 9'h000, 1, 1, 1, 32'h000000C3, 0);
    add(0, 9'h000, 1, 1, 0, 32'h000000C3, 0);
    add(1, 9'h0D1, 1, 1, 0, 32'h000000C3, 0);
    add(1, 9'h0D2, 1, 1, 0, 32'h000000C3, 1);
    add(1, 9'h0D3, 1, 1, 0, 32'h000000C3, 1);
    add(1, 9'h1D4, 1, 1, 0, 32'h000000C3, 1);
    add(0, 9'h000, 1, 1, 1, 32'hD4D3D2D1, 0);
    add(0, 9'h000, 1, 1, 0, 32'hD4D3D2D1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].val, vecs[i].data, vecs[i].ordy);
      check($sformatf("vec%0d_irdy", i), 32'(i_stream_rdy), 32'(vecs[i].e_irdy));
      check($sformatf("vec%0d_oval", i), 32'(o_stream_val), 32'(vecs[i].e_oval));
      check($sformatf("vec%0d_odata", i), o_stream_data, vecs[i].e_odata);
      check($sformatf("vec%0d_partial", i), 32'(partial), 32'(vecs[i].e_part));
    end

    // reset in the middle of a word
    drive(1, 9'h011, 1);
    drive(1, 9'h022, 1);
    drive(0, 9'h000, 1);
    check("midrst_partial_before", 32'(partial), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_oval", 32'(o_stream_val), 32'd0);
    check("midrst_odata", o_stream_data, 32'd0);
    check("midrst_partial", 32'(partial), 32'd0);
    check("midrst_irdy", 32'(i_stream_rdy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 9'h055, 1);
    drive(1, 9'h066, 1);
    drive(1, 9'h077, 1);
    drive(1, 9'h088, 1);
    drive(0, 9'h000, 1);
    check("postrst_oval", 32'(o_stream_val), 32'd1);
    check("postrst_odata", o_stream_data, 32'h88776655);
    check("postrst_partial", 32'(partial), 32'd0);
    drive(0, 9'h000, 1);

    // random streaming vs reference model
    sent = 0;
    cyc = 0;
    have = 1'b0;
    ch = '0;
    while (sent < 100 && cyc < 3000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ch = make_chunk($urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)));
        have = 1'b1;
      end
      drive(have, have ? 9'(ch) : 9'h000, $urandom_range(0, 2) != 0);
      observe();
      if (have && i_stream_rdy) begin
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 9'h000, 1);
      observe();
    end
    check("rand_sent", 32'(sent), 32'd100);
    check("rand_words_left", 32'(exp_q.size()), 32'd0);
    check("rand_rdy_rule", 32'(rule_viol), 32'd0);
    check("rand_partial", 32'(partial), 32'(cur_bytes.size() != 0));

`ifdef GPIO_PACKER_TIMEOUT_EN
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1, 9'h05A, 1);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 9'h000, 1);
      check($sformatf("tmo_idle%0d_oval", i), 32'(o_stream_val), 32'd0);
    end
    drive(0, 9'h000, 1);
    check("tmo_flush_oval", 32'(o_stream_val), 32'd1);
    check("tmo_flush_odata", o_stream_data, 32'h0000005A);
    check("tmo_flush_partial", 32'(partial), 32'd0);
    drive(0, 9'h000, 1);
    drive(1, 9'h0A5, 1);
    for (int i = 1; i <= 14; i++) drive(0, 9'h000, 1);
    drive(1, 9'h0B6, 1);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 9'h000, 1);
      check($sformatf("tmo2_idle%0d_oval", i), 32'(o_stream_val), 32'd0);
    end
    drive(0, 9'h000, 1);
    check("tmo2_flush_oval", 32'(o_stream_val), 32'd1);
    check("tmo2_flush_odata", o_stream_data, 32'h0000B6A5);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_word_packer.md
Name: gpio_word_packer

Overview:
- Upstream feeder for crossbar input port 1. Collects byte-wide GPIO chunks, arriving on the 9-bit GPIO bus as a val/rdy stream, into full 32-bit words.
- Emits each completed word as a val/rdy stream into the crossbar, so adders receive full words instead of zero-extended 9-bit values.
- Bit 8 of each GPIO chunk is a "last" marker that closes a short word early.

Parameters:
- BIT_WIDTH, 32, output word width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8, payload bits per input chunk.
- TIMEOUT_CYCLES, 16, idle cycles before a partial word is flushed (used only with the optional feature); must be ≥1.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_stream_val  input  1  chunk valid.
- i_stream_data  input  CHUNK_WIDTH+1  [CHUNK_WIDTH] = last flag, [CHUNK_WIDTH-1:0] = payload.
- i_stream_rdy  output  1  chunk accepted when val&rdy.
- o_stream_val  output  1  packed word valid.
- o_stream_data  output  BIT_WIDTH  packed word.
- o_stream_rdy  input  1  downstream (crossbar) ready.
- partial  output  1  high when the accumulator holds ≥1 chunk not yet emitted.

Behaviour:
- N = BIT_WIDTH/CHUNK_WIDTH (4 by default). State:
  - accumulator acc[BIT_WIDTH-1:0]
  - chunk counter cnt[clog2(N)-1:0]
  - output register out_data
  - out_val
- Reset asserted (reset=0), asynchronously:
  - acc=0, cnt=0, out_data=0, out_val=0, timer=0.
  - Outputs: o_stream_val=0, o_stream_data=0, partial=0.
  - i_stream_rdy=1 (out_val=0).
- Reset mid-word discards the partial word and any held output word; nothing is emitted.
- Handshake rules:
  - i_stream_rdy = !out_val || o_stream_rdy. This is combinational from o_stream_rdy and independent of i_stream_data.
  - o_stream_val = out_val.
  - o_stream_data = out_data, held stable while o_stream_val && !o_stream_rdy.
- Chunk accept (i_stream_val && i_stream_rdy):
  - Write acc[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] = payload. First chunk goes to the LSBs (little-endian).
  - Complete when cnt==N-1 or the last flag is set. On completion:
    - out_data = merged word with all unwritten upper chunks zero.
    - out_val=1, cnt=0, acc=0.
  - Otherwise cnt=cnt+1.
- Output drain: on o_stream_val && o_stream_rdy, out_val=0 unless a completion loads a new word in the same cycle. In that case out_val stays 1 with the new data. This gives zero-bubble throughput of one word per N chunk cycles.
- Latency: completing chunk accepted at edge k → o_stream_val high after edge k (visible in cycle k+1).
- Last flag on the first chunk → word = {24'b0, payload}.
- Last flag with cnt==N-1 → normal full word; no extra word is produced.
- While out_val=1 and o_stream_rdy=0, no chunks are accepted (including non-completing ones), so the accumulator never overruns.
- partial = (cnt != 0).

Optional Feature:
- Macro: GPIO_PACKER_TIMEOUT_EN.
- Defined:
  - timer increments each cycle with cnt!=0 and no chunk accept; it resets to 0 on any accept or on a flush.
  - When timer reaches TIMEOUT_CYCLES and (!out_val || o_stream_rdy), flush acc to out_data, zero-padded, identical to a last-flagged completion. Then out_val=1, cnt=0, timer=0.
  - If the output is blocked, timer saturates at TIMEOUT_CYCLES until the flush can occur.
  - A chunk accept in the same cycle takes priority and resets the timer, so no flush happens that cycle.
- Undefined: no timer logic exists; a partial word waits indefinitely for more chunks or a last flag. TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package holds:
  - stream width constant WORD_BITS=32
  - GPIO_CHUNK_BITS=8
  - GPIO_LAST_BIT index 8
  - typedef for the 9-bit GPIO chunk (last + payload)
- One natural sub-module: gpio_packer_out_reg, a single-entry val/rdy output register with load/drain and pass-through ready. It is reusable for the matching downstream unpacker.

Test Plan:
- Chunks 0x11,0x22,0x33,0x44, no last, o_stream_rdy=1 → one word 0x44332211, o_stream_val high the cycle after the 4th accept, partial=0 afterward.
- Chunks 0xAA, then 0x1BB (last set) → word 0x0000BBAA; next chunks 0x01,0x02,0x03,0x04 → 0x04030201.
- Hold o_stream_rdy=0 after word 0x44332211 → i_stream_rdy=0, output stable 10 cycles. Release with 4 new chunks queued → first word drained, back-to-back second word, no bubble, no chunk lost.
- Two chunks (cnt=2), assert reset=0 mid-cycle → outputs immediately zero, partial=0. After release, a full 4-chunk word emits correctly, with no stale bytes.
- GPIO_PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=16: single chunk 0x5A then idle → word 0x0000005A appears exactly 16 idle cycles later.
- Same setup, a chunk arriving on idle cycle 15 → no flush, timer resets.
- Back-to-back streaming 100 random chunks with random o_stream_rdy, scoreboard vs a reference model → exact word sequence; i_stream_rdy never high while out_val && !o_stream_rdy.
